i2s_tx: RTL and testbench
=========================

// Module: i2s_tx
// PURPOSE
// I2S master transmitter for a stereo 24-bit DAC (PCM5102-class). It is the playback counterpart of the
// PCM1808 capture path and uses the same clock plan from a 12 MHz clk:
//   scki = clk (256*Fs), bck = clk/4 (64*Fs), lrck = clk/256 (Fs = 46.875 kHz).
// Stereo samples arrive on a valid/ready port into a one-deep holding buffer. They are serialised MSB-first, I2S format.
// PARAMETERS
// DATA_W  24  sample width per channel; legal range 1..31 (a half-frame is 32 bck slots)
// PORTS
// clk            in   1       12 MHz system clock; all flops on posedge clk
// reset          in   1       asynchronous, active-low reset (0 = reset asserted)
// in_left        in   DATA_W  left sample, two's complement
// in_right       in   DATA_W  right sample, two's complement
// in_valid       in   1       sample pair valid
// in_ready       out  1       holding buffer empty; transfer occurs when in_valid && in_ready at posedge clk
// clr_underrun   in   1       synchronous clear of underrun_sticky
// scki           out  1       DAC system clock = clk (combinational pass-through)
// bck            out  1       bit clock = prescaler[1]
// lrck           out  1       word clock = prescaler[7]; 0 = left, 1 = right
// dout           out  1       serial data to DAC DIN (registered)
// frame_start    out  1       1-clk pulse on the clk following each prescaler 255->0 wrap
// underrun       out  1       1-clk pulse, same cycle as frame_start, when no sample was pending
// underrun_sticky out 1       set by underrun, cleared by clr_underrun (set wins if both happen together)
// BEHAVIOUR
// - Reset (reset=0, async): prescaler=0, so bck=0 and lrck=0. dout=0, in_ready=0, pending empty,
//   active_l/active_r=0, frame_start=0, underrun=0, underrun_sticky=0.
//   in_ready goes to 1 on the first clk after reset release.
// - Prescaler: 8-bit free-running counter, +1 every clk, wraps 255->0.
//   Slot index = prescaler[6:2] (0..31). Channel = prescaler[7].
// - dout is registered from the next prescaler value. As a result, dout changes only on the clk edge where bck falls
//   (prescaler[1:0] 3->0), and it is stable across each bck rising edge, where the DAC samples it.
// - Slot map per half-frame:
//   - slot 0: 0 (the one-bck I2S delay after an lrck edge)
//   - slots 1..DATA_W: active word bits MSB..LSB
//   - slots DATA_W+1..31: 0
// - Buffering: a one-entry pending register holds {L,R}. in_ready = !pending_full.
//   Accepting a transfer sets pending_full.
// - Frame boundary (the clk edge where prescaler goes 255->0):
//   - if pending_full: active <= pending; pending_full <= 0; in_ready rises on the next clk.
//   - else: active <= 0 (silence), underrun pulse, underrun_sticky <= 1.
//   - A transfer accepted on the boundary edge itself (pending was empty) counts as an underrun for this frame.
//     That sample is played in the following frame.
// - The load takes effect in slot 0, which is always 0, so bits for slot 1 come from the new active word.
//   Latency: accept -> MSB on dout is at most 1 frame + 4 clk.
// - Left is sent while lrck=0; right is sent while lrck=1. Both come from the same active pair, so the channels never tear.
// - Reset mid-frame: all state is discarded immediately; the pending sample is lost. No partial word is emitted after release.
// - DATA_W=31: slot 31 carries the LSB and no padding slots remain.
// TESTING
// 1. Release reset; write L=0xA5A5A5, R=0x5A5A5A at clk 10.
//    -> in_ready=0 from clk 11 to 256. A bench I2S receiver (sampling on bck rise, skipping slot 0) reads
//       L=0xA5A5A5, R=0x5A5A5A in the frame starting at clk 256.
// 2. Clock check
//    -> bck period = 4 clk, lrck period = 256 clk, lrck toggles only while bck=0.
//       dout never changes on a bck rising edge. Left MSB appears in slot 1 (clk 260..263 after the wrap).
// 3. Back-pressure: hold in_valid=1 with a new pair every accept
//    -> exactly one accept per 256 clk. Samples come out in order, with no duplicates and no drops.
// 4. No write for one frame
//    -> dout=0 for the whole frame; underrun=1 for exactly 1 clk, coincident with frame_start; sticky=1.
//       clr_underrun=1 -> sticky=0 next clk.
// 5. Assert reset at prescaler=100 with a pending sample
//    -> bck, lrck, dout, in_ready = 0 immediately. After release the first frame is silent and underrun fires at the first wrap.
// 6. Patterns L=0x800000, R=0x7FFFFF, and DATA_W=16 with L=0x8001
//    -> correct MSB-first bits, and padding slots read 0.

Source files
------------

// File: rtl/i2s_tx.sv
// i2s_tx: I2S master transmitter for a stereo two's-complement DAC.
// Derives scki/bck/lrck from clk through an 8-bit prescaler (256/64/1 x Fs).
// Accepts one stereo pair at a time into a one-deep holding buffer and serialises it MSB-first.
// Ports:
//   clk, reset (async, active-low)
//   in_left, in_right, in_valid, in_ready : valid/ready sample-pair input
//   clr_underrun                          : synchronous clear of underrun_sticky
//   scki, bck, lrck, dout                 : DAC serial interface
//   frame_start, underrun                 : 1-clk pulses after each frame wrap
//   underrun_sticky                       : latched underrun flag
module i2s_tx #(
  parameter int unsigned DATA_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_left,
  input  logic [DATA_W-1:0] in_right,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              clr_underrun,
  output logic              scki,
  output logic              bck,
  output logic              lrck,
  output logic              dout,
  output logic              frame_start,
  output logic              underrun,
  output logic              underrun_sticky
);

  localparam int unsigned PRESC_W = 8;
  localparam int unsigned SLOT_W  = 5;
  localparam int unsigned HALF_W  = 32;
  localparam int unsigned PAD_W   = HALF_W - 1 - DATA_W;

  logic [PRESC_W-1:0] prescaler;
  logic [PRESC_W-1:0] prescaler_nxt;
  logic               pending_full;
  logic               pending_full_nxt;
  logic [DATA_W-1:0]  pend_l;
  logic [DATA_W-1:0]  pend_r;
  logic [DATA_W-1:0]  pend_l_nxt;
  logic [DATA_W-1:0]  pend_r_nxt;
  logic [DATA_W-1:0]  act_l;
  logic [DATA_W-1:0]  act_r;
  logic [DATA_W-1:0]  act_l_nxt;
  logic [DATA_W-1:0]  act_r_nxt;
  logic               in_ready_nxt;
  logic               dout_nxt;
  logic               frame_start_nxt;
  logic               underrun_nxt;
  logic               sticky_nxt;
  logic               wrap;
  logic               accept;
  logic               load;
  logic [SLOT_W-1:0]  slot;
  logic [HALF_W-1:0]  half_bits;

  // DAC system clock is the system clock itself
  assign scki = clk;

  // Bit and word clocks are taps of the prescaler register
  assign bck  = prescaler[1];
  assign lrck = prescaler[7];

  // Next-state: prescaler, buffering, frame-boundary load and serial bit select
  always_comb begin
    prescaler_nxt    = prescaler + PRESC_W'(1);
    wrap             = (prescaler == '1);
    accept           = in_valid && in_ready;
    load             = wrap && pending_full;
    pending_full_nxt = pending_full;
    pend_l_nxt       = pend_l;
    pend_r_nxt       = pend_r;
    act_l_nxt        = act_l;
    act_r_nxt        = act_r;

    // Frame boundary: play the pending pair, or silence if none arrived in time
    if (wrap) begin
      act_l_nxt = pending_full ? pend_l : '0;
      act_r_nxt = pending_full ? pend_r : '0;
    end
    if (load) begin
      pending_full_nxt = 1'b0;
    end
    // An accept on the boundary edge lands in pending and waits for the next frame
    if (accept) begin
      pending_full_nxt = 1'b1;
      pend_l_nxt       = in_left;
      pend_r_nxt       = in_right;
    end

    // Ready reopens one clk after the load that emptied the buffer
    in_ready_nxt    = !pending_full_nxt && !load;
    frame_start_nxt = wrap;
    underrun_nxt    = wrap && !pending_full;
    sticky_nxt      = underrun_nxt ? 1'b1 : (clr_underrun ? 1'b0 : underrun_sticky);

    // Half-frame image: bit 31 is slot 0 (always 0), MSB in slot 1, zero padding after LSB
    slot      = prescaler_nxt[6:2];
    half_bits = HALF_W'(prescaler_nxt[7] ? act_r_nxt : act_l_nxt) << PAD_W;
    dout_nxt  = half_bits[~slot];
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescaler       <= '0;
      pending_full    <= 1'b0;
      pend_l          <= '0;
      pend_r          <= '0;
      act_l           <= '0;
      act_r           <= '0;
      in_ready        <= 1'b0;
      dout            <= 1'b0;
      frame_start     <= 1'b0;
      underrun        <= 1'b0;
      underrun_sticky <= 1'b0;
    end else begin
      prescaler       <= prescaler_nxt;
      pending_full    <= pending_full_nxt;
      pend_l          <= pend_l_nxt;
      pend_r          <= pend_r_nxt;
      act_l           <= act_l_nxt;
      act_r           <= act_r_nxt;
      in_ready        <= in_ready_nxt;
      dout            <= dout_nxt;
      frame_start     <= frame_start_nxt;
      underrun        <= underrun_nxt;
      underrun_sticky <= sticky_nxt;
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: drives a 24-bit and a 16-bit i2s_tx in lockstep and checks them against a
// frame-level model (pending slot, played pair per frame) plus a bench-side I2S receiver.
module tb_i2s_tx;

  localparam int unsigned NI = 2;
  localparam int unsigned W0 = 24;
  localparam int unsigned W1 = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]   drv_l [NI];
  logic [31:0]   drv_r [NI];
  logic [NI-1:0] valid;
  logic [NI-1:0] clr;
  logic [NI-1:0] ready, scki, bck, lrck, dout, fs, und, stk;

  i2s_tx #(.DATA_W(W0)) u_dut24 (
    .clk(clk), .reset(reset),
    .in_left(drv_l[0][W0-1:0]), .in_right(drv_r[0][W0-1:0]),
    .in_valid(valid[0]), .in_ready(ready[0]), .clr_underrun(clr[0]),
    .scki(scki[0]), .bck(bck[0]), .lrck(lrck[0]), .dout(dout[0]),
    .frame_start(fs[0]), .underrun(und[0]), .underrun_sticky(stk[0])
  );

  i2s_tx #(.DATA_W(W1)) u_dut16 (
    .clk(clk), .reset(reset),
    .in_left(drv_l[1][W1-1:0]), .in_right(drv_r[1][W1-1:0]),
    .in_valid(valid[1]), .in_ready(ready[1]), .clr_underrun(clr[1]),
    .scki(scki[1]), .bck(bck[1]), .lrck(lrck[1]), .dout(dout[1]),
    .frame_start(fs[1]), .underrun(und[1]), .underrun_sticky(stk[1])
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc;
  bit          mp_full [NI];
  logic [31:0] mp_l [NI], mp_r [NI];
  logic [31:0] cur_l [NI], cur_r [NI];
  logic [31:0] rx_l [NI], rx_r [NI];
  bit          exp_rdy [NI], exp_stk [NI];
  int          bad [NI], pad_bad [NI];
  bit          fired [NI];
  int          last_fire [NI];

  function automatic int unsigned wid(input int i);
    return (i == 0) ? W0 : W1;
  endfunction

  function automatic logic [31:0] mask(input int i);
    return 32'((64'd1 << wid(i)) - 64'd1);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0;
    for (int i = 0; i < NI; i++) begin
      mp_full[i] = 0; mp_l[i] = '0; mp_r[i] = '0;
      cur_l[i] = '0; cur_r[i] = '0; rx_l[i] = '0; rx_r[i] = '0;
      exp_rdy[i] = 0; exp_stk[i] = 0; bad[i] = 0; pad_bad[i] = 0;
      fired[i] = 0; last_fire[i] = -1;
    end
  endtask

  // One clk: advance the model, check per-cycle behaviour, run the receiver
  task automatic tick();
    logic [NI-1:0] pdout, plrck;
    bit            fire [NI];
    logic [7:0]    ph;
    pdout = dout;
    plrck = lrck;
    for (int i = 0; i < NI; i++) fire[i] = valid[i] && exp_rdy[i];
    @(posedge clk);
    #1;
    cyc++;
    ph = 8'(cyc);
    for (int i = 0; i < NI; i++) begin
      bit wrap, loaded, exp_und;
      int s;
      wrap = (ph == 8'd0);
      loaded = 0;
      exp_und = 0;
      fired[i] = fire[i];
      if (fire[i]) last_fire[i] = cyc;
      if (wrap) begin
        check($sformatf("frame_left%0d@%0d", i, cyc), 64'(rx_l[i]), 64'(cur_l[i]));
        check($sformatf("frame_right%0d@%0d", i, cyc), 64'(rx_r[i]), 64'(cur_r[i]));
        check($sformatf("frame_padding%0d@%0d", i, cyc), 64'(pad_bad[i]), 64'd0);
        check($sformatf("frame_timing%0d@%0d", i, cyc), 64'(bad[i]), 64'd0);
        rx_l[i] = '0; rx_r[i] = '0; pad_bad[i] = 0; bad[i] = 0;
        if (mp_full[i]) begin
          cur_l[i] = mp_l[i]; cur_r[i] = mp_r[i]; mp_full[i] = 0; loaded = 1;
        end else begin
          cur_l[i] = '0; cur_r[i] = '0; exp_und = 1;
        end
      end
      if (fire[i]) begin
        mp_full[i] = 1;
        mp_l[i] = drv_l[i] & mask(i);
        mp_r[i] = drv_r[i] & mask(i);
      end
      exp_stk[i] = exp_und ? 1'b1 : (clr[i] ? 1'b0 : exp_stk[i]);
      exp_rdy[i] = !mp_full[i] && !loaded;
      if (bck[i] !== ph[1] || lrck[i] !== ph[7] || scki[i] !== 1'b1) bad[i]++;
      if (fs[i] !== wrap || und[i] !== exp_und) bad[i]++;
      if (stk[i] !== exp_stk[i] || ready[i] !== exp_rdy[i]) bad[i]++;
      if (dout[i] !== pdout[i] && ph[1:0] != 2'd0) bad[i]++;
      if (lrck[i] !== plrck[i] && bck[i] !== 1'b0) bad[i]++;
      // Receiver: bck has just risen; take the bit the DAC would latch
      if (ph[1:0] == 2'd2) begin
        s = int'(ph[6:2]);
        if (s >= 1 && s <= int'(wid(i))) begin
          if (ph[7]) rx_r[i] = {rx_r[i][30:0], dout[i]};
          else       rx_l[i] = {rx_l[i][30:0], dout[i]};
        end else if (dout[i] !== 1'b0) begin
          pad_bad[i]++;
        end
      end
    end
  endtask

  task automatic send(input int i, input logic [31:0] l, input logic [31:0] r, input bit keep_valid);
    int n;
    n = 0;
    drv_l[i] = l;
    drv_r[i] = r;
    valid[i] = 1'b1;
    fired[i] = 0;
    while (!fired[i] && n < 600) begin
      tick();
      n++;
    end
    check($sformatf("accepted%0d@%0d", i, cyc), 64'(fired[i]), 64'd1);
    if (!keep_valid) valid[i] = 1'b0;
  endtask

  task automatic run_to_wrap();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (8'(cyc) != 8'd0 && n < 300);
  endtask

  task automatic run_to_phase(input int p);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (int'(8'(cyc)) != p && n < 300);
  endtask

  initial begin
    int prev;
    logic [31:0] l, r;
    for (int i = 0; i < NI; i++) begin
      drv_l[i] = '0;
      drv_r[i] = '0;
    end
    valid = '0;
    clr = '0;
    model_reset();

    // Reset state
    #12;
    for (int i = 0; i < NI; i++)
      check($sformatf("reset_outputs%0d", i), 64'({ready[i], bck[i], lrck[i], dout[i], fs[i], und[i], stk[i]}), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // First write lands on clk 10; MSB slot timing and ready window checked directly
    while (cyc < 9) tick();
    drv_l[1] = 32'h8001;
    drv_r[1] = $urandom() & mask(1);
    valid[1] = 1'b1;
    send(0, 32'hA5A5A5, 32'h5A5A5A, 0);
    valid[1] = 1'b0;
    check("t1_accept_cycle", 64'(last_fire[0]), 64'd10);
    check("t1_ready_low_after_accept", 64'(ready[0]), 64'd0);
    while (cyc < 256) tick();
    check("t1_ready_low_at_wrap", 64'(ready[0]), 64'd0);
    check("t1_frame_start_at_wrap", 64'(fs[0]), 64'd1);
    tick();
    check("t1_ready_high_257", 64'(ready[0]), 64'd1);
    while (cyc < 259) tick();
    check("t2_slot0_zero", 64'(dout[0]), 64'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("t2_left_msb@%0d", cyc), 64'({bck[0], dout[0]}), 64'({1'(k >= 2), 1'b1}));
    end

    // Extreme values on the 24-bit channel, random pair on the 16-bit one
    l = $urandom() & mask(1);
    r = $urandom() & mask(1);
    drv_l[1] = l;
    drv_r[1] = r;
    valid[1] = 1'b1;
    send(0, 32'h800000, 32'h7FFFFF, 0);
    valid[1] = 1'b0;
    check("t6_pair16_taken", 64'(last_fire[1]), 64'(last_fire[0]));

    // Back-pressure: valid held high, a fresh random pair offered after every accept
    prev = 0;
    for (int k = 0; k < 6; k++) begin
      l = $urandom() & mask(0);
      r = $urandom() & mask(0);
      send(0, l, r, 1);
      if (k > 0) check($sformatf("t3_accept_gap%0d", k), 64'(cyc - prev), 64'd256);
      prev = cyc;
    end
    valid[0] = 1'b0;

    // Starve the 24-bit channel: one frame plays the last pair, the next is silent
    run_to_wrap();
    check("t4_loaded_no_underrun", 64'(und[0]), 64'd0);
    run_to_wrap();
    check("t4_underrun_with_frame_start", 64'({und[0], fs[0], stk[0]}), 64'b111);
    tick();
    check("t4_underrun_one_clk", 64'({und[0], stk[0]}), 64'b01);
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    check("t4_sticky_cleared", 64'(stk[0]), 64'd0);
    run_to_wrap();

    // Reset mid-frame with a pending sample
    send(0, $urandom() & mask(0), $urandom() & mask(0), 0);
    run_to_phase(100);
    check("t5_pending_before_reset", 64'(ready[0]), 64'd0);
    reset = 1'b0;
    #1;
    check("t5_outputs_in_reset", 64'({bck[0], lrck[0], dout[0], ready[0], stk[0]}), 64'd0);
    repeat (3) @(negedge clk);
    model_reset();
    reset = 1'b1;
    run_to_wrap();
    check("t5_underrun_first_wrap", 64'({und[0], fs[0]}), 64'b11);
    check("t5_cycle_of_first_wrap", 64'(cyc), 64'd256);

    // Random pairs on both channels, then drain
    for (int k = 0; k < 3; k++) begin
      drv_l[1] = $urandom() & mask(1);
      drv_r[1] = $urandom() & mask(1);
      valid[1] = 1'b1;
      send(0, $urandom() & mask(0), $urandom() & mask(0), 0);
      valid[1] = 1'b0;
      run_to_wrap();
    end
    run_to_wrap();
    run_to_wrap();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
